// File: rtl/param_wr_ram.sv
// Simple-dual-port RAM: one write port, one read port, lane write enables, optional clear-on-reset.
// Latency: read data 1 cycle after re (2 cycles with OUT_REG=1); writes land at the sampling edge.
// Backpressure: none on the user port; while busy the clear sequencer owns the array and we/re are ignored.
module param_wr_ram #(
    parameter int                DATA_W    = 8,
    parameter int                LANE_W    = 8,
    parameter int                ADDR_W    = 12,
    parameter int                DEPTH     = 4096,
    parameter int                RDW_MODE  = 0,
    parameter int                OUT_REG   = 0,
    parameter string             INIT_FILE = "./fillmem.txt",
    parameter int                CLEAR_EN  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          d,
    input  logic [ADDR_W-1:0]          write_address,
    input  logic [(DATA_W/LANE_W)-1:0] we,
    input  logic [ADDR_W-1:0]          read_address,
    input  logic                       re,
    output logic [DATA_W-1:0]          q,
    output logic                       q_valid,
    output logic                       busy
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   clr_addr_q, clr_addr_d;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              rd_fire;
    logic              same_addr;
    logic [LANES-1:0]  wr_lane_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  rd_idx;

    logic [DATA_W-1:0] ram_q;
    logic              vld1_q;
    logic              zero_q;
    logic [LANES-1:0]  byp_en_q;
    logic [DATA_W-1:0] byp_d_q;
    logic [DATA_W-1:0] q0;

    assign busy        = (state_q == S_CLEAR);
    assign wr_in_range = ({1'b0, write_address} < DEPTH_L);
    assign rd_in_range = ({1'b0, read_address} < DEPTH_L);
    assign rd_fire     = re && !busy && !rst;
    assign same_addr   = wr_in_range && (write_address == read_address);
    assign rd_idx      = rd_in_range ? read_address[IDX_W-1:0] : '0;

    // Clear sequencer state register; rst (re)starts the scrub from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_EN != 0) ? S_CLEAR : S_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear sequencer next state: one word per cycle, leave after the last word is written.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            S_CLEAR: begin
                if (clr_addr_q == DEPTH_L - 1'b1) begin
                    state_d    = S_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (CLEAR_EN == 0) begin
            state_d = S_IDLE;
        end
    end

    // Write-port mux: scrubber owns the port while busy, otherwise the user (in-range only).
    always_comb begin
        wr_lane_en = '0;
        wr_idx     = '0;
        wr_data    = d;
        if (!rst) begin
            if (busy) begin
                wr_lane_en = '1;
                wr_idx     = clr_addr_q[IDX_W-1:0];
                wr_data    = CLEAR_VAL;
            end else if (wr_in_range) begin
                wr_lane_en = we;
                wr_idx     = write_address[IDX_W-1:0];
            end
        end
    end

    // Plain read-first array with lane enables so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lane_en[i]) begin
                mem[wr_idx][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
            end
        end
        if (rd_fire) begin
            ram_q <= mem[rd_idx];
        end
    end

    // Side-band captured with each read: valid, force-zero, and same-address bypass lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld1_q   <= 1'b0;
            zero_q   <= 1'b1;
            byp_en_q <= '0;
            byp_d_q  <= '0;
        end else begin
            vld1_q <= rd_fire;
            if (rd_fire) begin
                zero_q   <= !rd_in_range;
                byp_en_q <= (RDW_MODE == 0 && same_addr) ? we : '0;
                byp_d_q  <= d;
            end
        end
    end

    // Merge bypassed lanes over the array output; reset and out-of-range reads show zero.
    always_comb begin
        q0 = '0;
        if (!zero_q) begin
            for (int i = 0; i < LANES; i++) begin
                q0[i*LANE_W +: LANE_W] = byp_en_q[i] ? byp_d_q[i*LANE_W +: LANE_W]
                                                     : ram_q[i*LANE_W +: LANE_W];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q2_q;
            logic              vld2_q;

            // Free-running second stage; data and valid move together.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q2_q   <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    q2_q   <= q0;
                    vld2_q <= vld1_q;
                end
            end

            assign q       = q2_q;
            assign q_valid = vld2_q;
        end else begin : g_no_out_reg
            assign q       = q0;
            assign q_valid = vld1_q;
        end
    endgenerate

endmodule
